// File: rtl/ps2_defs.sv
// Shared PS/2 definitions: frame layout, default timing parameters and state encoding.
// Kept separate so a PS/2 transmitter can use the same constants.
package ps2_defs;

  localparam int DEF_FILTER_LEN = 8;
  localparam int DEF_TIMEOUT    = 5000;
  localparam int FRAME_BITS     = 11;
  localparam int DATA_BITS      = FRAME_BITS - 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // Odd parity: the data bits and the parity bit together hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Purpose: 2-flop synchroniser plus level filter for a slow asynchronous line.
// Latency: level and fall change FILTER_LEN+2 cycles after a stable raw edge.
// Backpressure: none; fall is a one-cycle strobe that cannot be stalled.
module ps2_line_filter
  import ps2_defs::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clock50,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // Reset to the bus idle level so releasing reset never looks like an edge.
  always_ff @(posedge clock50) begin
    if (reset) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      fall  <= 1'b0;
      cnt   <= '0;
    end else begin
      meta <= line;
      sync <= meta;
      fall <= 1'b0;
      if (sync != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync;
          fall  <= ~sync;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// Purpose: PS/2 device-to-host frame receiver with glitch filter, parity check and timeout.
// Latency: ps2_data/ps2_data_clk update one cycle after the filtered stop-bit fall.
// Backpressure: none; ps2_data_clk and ps2_err are one-cycle strobes the consumer must catch.
module ps2_receiver
  import ps2_defs::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic       clock50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_data,
  output logic       ps2_data_clk,
  output logic       ps2_err
);

  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

  logic                 clk_level;
  logic                 clk_fall_stb;
  logic                 clk_fall;
  logic                 dat_meta;
  logic                 dat_sync;
  ps2_state_t           state;
  logic [BCW-1:0]       bit_cnt;
  logic [TW-1:0]        tmo_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_ok;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clock50(clock50),
    .reset  (reset),
    .line   (ps2_clk),
    .level  (clk_level),
    .fall   (clk_fall_stb)
  );

  assign clk_fall = clk_fall_stb & ~clk_level;

  // The data line only needs synchronising: the device holds it stable for
  // the whole clock-low phase, well beyond the clock filter delay.
  always_ff @(posedge clock50) begin
    if (reset) begin
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      dat_meta <= ps2_dat;
      dat_sync <= dat_meta;
    end
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      tmo_cnt      <= '0;
      shift_reg    <= '0;
      parity_ok    <= 1'b0;
      ps2_data     <= 8'h00;
      ps2_data_clk <= 1'b0;
      ps2_err      <= 1'b0;
    end else begin
      ps2_data_clk <= 1'b0;
      ps2_err      <= 1'b0;
      if (clk_fall) begin
        // A fall always wins over a timeout landing in the same cycle.
        tmo_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (!dat_sync) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shift_reg <= {dat_sync, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              state <= ST_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ST_PARITY: begin
            parity_ok <= odd_parity_ok(shift_reg, dat_sync);
            state     <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (dat_sync && parity_ok) begin
              ps2_data     <= shift_reg;
              ps2_data_clk <= 1'b1;
            end else begin
              ps2_err <= 1'b1;
            end
          end
        endcase
      end else if (state == ST_IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_LAST) begin
        state     <= ST_IDLE;
        ps2_err   <= 1'b1;
        tmo_cnt   <= '0;
        bit_cnt   <= '0;
        shift_reg <= '0;
        parity_ok <= 1'b0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Randomised PS/2 frame bench with a queue scoreboard and a frame-level reference model.
module tb_ps2_receiver;

  logic       clock50 = 1'b0;
  logic       reset   = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] ps2_data;
  logic       ps2_data_clk;
  logic       ps2_err;

  always #10 clock50 = ~clock50;

  ps2_receiver dut (
    .clock50     (clock50),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .ps2_data    (ps2_data),
    .ps2_data_clk(ps2_data_clk),
    .ps2_err     (ps2_err)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] val;
  } exp_t;

  exp_t       expq[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         last_err_cyc = -1;
  int         last_fall_cyc = 0;
  int         data_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clock50) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock50);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~^d;
    if (bad_par) p = ~p;
    return {~bad_stop, p, d, 1'b0};
  endfunction

  // Reference model: a frame is good when start=0, stop=1 and bits 1..9 hold an odd count of ones.
  task automatic expect_frame(input logic [10:0] f);
    int   ones;
    exp_t e;
    ones = 0;
    for (int i = 1; i <= 9; i++) ones += int'(f[i]);
    if (f[0] == 1'b0 && f[10] == 1'b1 && (ones % 2) == 1) begin
      e.is_err = 1'b0;
      e.val    = f[8:1];
    end else begin
      e.is_err = 1'b1;
      e.val    = 8'h00;
    end
    expq.push_back(e);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      ps2_dat = f[i];
      cycles(half);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      cycles(half);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [10:0] f, input int half);
    expect_frame(f);
    send_bits(f, 11, half);
    ps2_dat = 1'b1;
    cycles(half);
  endtask

  // Monitor: every strobe consumes one scoreboard entry.
  always @(negedge clock50) begin
    exp_t e;
    if (!reset && (ps2_data_clk || ps2_err)) begin
      check("excl", 32'(ps2_data_clk & ps2_err), 32'd0);
      if (ps2_data_clk) data_cnt++;
      if (ps2_err) begin
        err_cnt++;
        last_err_cyc = cyc;
      end
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got data_clk=%0b err=%0b data=%0h want none",
                 ps2_data_clk, ps2_err, ps2_data);
      end else begin
        e = expq.pop_front();
        check("kind", 32'(ps2_err), 32'(e.is_err));
        if (ps2_data_clk) begin
          check("data", 32'(ps2_data), 32'(e.val));
          last_good = e.val;
        end else begin
          check("held", 32'(ps2_data), 32'(last_good));
        end
      end
    end
  end

  initial begin
    logic [10:0] f;
    int d0, e0, dt;

    cycles(5);
    check("rst_data", 32'(ps2_data), 32'h00);
    check("rst_strobe", 32'(ps2_data_clk), 32'd0);
    check("rst_err", 32'(ps2_err), 32'd0);
    reset = 1'b0;
    cycles(20);
    check("rel_no_strobe", 32'(data_cnt + err_cnt), 32'd0);

    // Frame 0x1C at the real 12.5 kHz bus rate.
    d0 = data_cnt; e0 = err_cnt;
    send_frame(make_frame(8'h1C, 1'b0, 1'b0), 2000);
    cycles(20);
    check("f1c_data", 32'(ps2_data), 32'h1C);
    check("f1c_cnt", 32'(data_cnt - d0), 32'd1);
    check("f1c_err", 32'(err_cnt - e0), 32'd0);

    // Same byte with the parity bit flipped.
    d0 = data_cnt; e0 = err_cnt;
    send_frame(make_frame(8'h1C, 1'b1, 1'b0), 40);
    cycles(20);
    check("par_data", 32'(ps2_data), 32'h1C);
    check("par_cnt", 32'(data_cnt - d0), 32'd0);
    check("par_err", 32'(err_cnt - e0), 32'd1);

    // Truncated frame then silence: timeout error, then a normal frame.
    e0 = err_cnt;
    begin
      exp_t te;
      te.is_err = 1'b1;
      te.val    = 8'h00;
      expq.push_back(te);
    end
    send_bits(make_frame(8'h55, 1'b0, 1'b0), 4, 40);
    ps2_dat = 1'b1;
    cycles(6000);
    check("tmo_err", 32'(err_cnt - e0), 32'd1);
    dt = last_err_cyc - last_fall_cyc;
    if (dt < 5000 || dt > 5030) begin
      total++;
      bad++;
      $display("FAIL tmo_at: got %0d cycles want 5000..5030", dt);
    end else begin
      total++;
    end
    d0 = data_cnt;
    send_frame(make_frame(8'hF0, 1'b0, 1'b0), 40);
    cycles(20);
    check("tmo_next", 32'(ps2_data), 32'hF0);
    check("tmo_next_cnt", 32'(data_cnt - d0), 32'd1);

    // Short low glitch on the clock with data low must not start a frame.
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    cycles(3);
    ps2_clk = 1'b1;
    cycles(2);
    ps2_dat = 1'b1;
    cycles(50);
    d0 = data_cnt;
    send_frame(make_frame(8'h29, 1'b0, 1'b0), 40);
    cycles(20);
    check("glitch_data", 32'(ps2_data), 32'h29);
    check("glitch_cnt", 32'(data_cnt - d0), 32'd1);

    // Reset in the middle of a frame.
    f = make_frame(8'h5A, 1'b0, 1'b0);
    d0 = data_cnt; e0 = err_cnt;
    send_bits(f, 5, 40);
    reset = 1'b1;
    ps2_dat = 1'b1;
    ps2_clk = 1'b1;
    cycles(4);
    check("mid_rst_data", 32'(ps2_data), 32'h00);
    reset = 1'b0;
    last_good = 8'h00;
    cycles(20);
    check("mid_rst_quiet", 32'(data_cnt - d0 + err_cnt - e0), 32'd0);
    send_frame(f, 40);
    cycles(20);
    check("mid_rst_data2", 32'(ps2_data), 32'h5A);

    // Back-to-back frames.
    d0 = data_cnt;
    send_frame(make_frame(8'hE0, 1'b0, 1'b0), 40);
    send_frame(make_frame(8'hF0, 1'b0, 1'b0), 40);
    send_frame(make_frame(8'h75, 1'b0, 1'b0), 40);
    cycles(20);
    check("b2b_cnt", 32'(data_cnt - d0), 32'd3);
    check("b2b_last", 32'(ps2_data), 32'h75);

    // Random frames, some corrupted, at random bus speeds.
    for (int k = 0; k < 25; k++) begin
      int r;
      r = $urandom_range(0, 7);
      send_frame(make_frame(8'($urandom), r == 0, r == 1), $urandom_range(20, 60));
      cycles($urandom_range(0, 100));
    end

    cycles(50);
    check("drain", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
